accum_writeback_controller: RTL

Read-modify-write accumulation stage that sits directly upstream of the ofmap output controller. It consumes OC0-lane partial sums from the MAC array and reads the running sum from the accumulation double buffer's write bank. It adds the two and writes the result back through the buffer's `ren/raddr_accum/rdata_accum` and `wen/waddr/wdata` ports. When every pixel of the bank has received all its passes, it raises `ready_to_switch` to the main FSM and holds until the banks are swapped.

---
 rtl/accum_pkg.sv | 22 ++
 rtl/accum_rmw_pipe.sv | 81 ++++++++
 rtl/accum_writeback_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared lane width, FSM states and config field helpers
package accum_pkg;

  localparam int LANE_WIDTH = 32;
  localparam int CFG_HALF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [CFG_HALF-1:0] cfg_pixels_m1(input logic [2*CFG_HALF-1:0] cfg);
    return cfg[CFG_HALF-1:0];
  endfunction

  function automatic logic [CFG_HALF-1:0] cfg_passes_m1(input logic [2*CFG_HALF-1:0] cfg);
    return cfg[2*CFG_HALF-1:CFG_HALF];
  endfunction

endpackage

// File: rtl/accum_rmw_pipe.sv
// rtl/accum_rmw_pipe.sv - stage-1 register, per-lane wrapping adders and write-after-write forwarding
module accum_rmw_pipe
  import accum_pkg::*;
#(
  parameter int OC0    = 4,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  input  logic                      in_first,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [LANE_WIDTH*OC0-1:0] in_psum,
  input  logic [LANE_WIDTH*OC0-1:0] rdata,
  output logic                      wen,
  output logic [ADDR_W-1:0]         waddr,
  output logic [LANE_WIDTH*OC0-1:0] wdata
);

  localparam int DW = LANE_WIDTH * OC0;

  logic              vld_q, vld_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     psum_q, psum_d;
  logic              prev_vld_q, prev_vld_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic [DW-1:0]     prev_wdata_q, prev_wdata_d;
  logic [DW-1:0]     addend;
  logic              fwd;

  // Idle cycles load zeros so wdata reads 0 whenever wen is low.
  always_comb begin
    vld_d        = in_vld;
    first_d      = in_vld & in_first;
    addr_d       = in_vld ? in_addr : '0;
    psum_d       = in_vld ? in_psum : '0;
    prev_vld_d   = vld_q;
    prev_addr_d  = addr_q;
    prev_wdata_d = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      addr_q       <= '0;
      psum_q       <= '0;
      prev_vld_q   <= 1'b0;
      prev_addr_q  <= '0;
      prev_wdata_q <= '0;
    end else begin
      vld_q        <= vld_d;
      first_q      <= first_d;
      addr_q       <= addr_d;
      psum_q       <= psum_d;
      prev_vld_q   <= prev_vld_d;
      prev_addr_q  <= prev_addr_d;
      prev_wdata_q <= prev_wdata_d;
    end
  end

  // The buffer read issued alongside last cycle's write to the same word returns stale data.
  assign fwd = prev_vld_q && (prev_addr_q == addr_q);

  always_comb begin
    addend = '0;
    wdata  = '0;
    if (vld_q && !first_q) begin
      addend = fwd ? prev_wdata_q : rdata;
    end
    for (int k = 0; k < OC0; k++) begin
      wdata[k*LANE_WIDTH +: LANE_WIDTH] = psum_q[k*LANE_WIDTH +: LANE_WIDTH]
                                        + addend[k*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  assign wen   = vld_q;
  assign waddr = addr_q;

endmodule

// File: rtl/accum_writeback_controller.sv
// rtl/accum_writeback_controller.sv - read-modify-write accumulation of MAC partial sums into the accum write bank
module accum_writeback_controller
  import accum_pkg::*;
#(
  parameter int OC0             = 4,
  parameter int CONFIG_WIDTH    = 32,
  parameter int BANK_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_enable,
  input  logic [CONFIG_WIDTH-1:0]    config_data,
  input  logic                       psum_vld,
  input  logic [32*OC0-1:0]          psum_dat,
  output logic                       psum_rdy,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr_accum,
  input  logic [32*OC0-1:0]          rdata_accum,
  output logic                       wen,
  output logic [BANK_ADDR_WIDTH-1:0] waddr,
  output logic [32*OC0-1:0]          wdata,
  output logic                       ready_to_switch,
  input  logic                       start_new_write_bank
);

  state_e              state_q, state_d;
  logic [CFG_HALF-1:0] pix_m1_q, pix_m1_d;
  logic [CFG_HALF-1:0] pass_m1_q, pass_m1_d;
  logic [CFG_HALF-1:0] pixel_q, pixel_d;
  logic [CFG_HALF-1:0] pass_q, pass_d;
  logic                accept;
  logic                last_pixel;
  logic                last_pass;
  logic [BANK_ADDR_WIDTH-1:0] addr;

  assign psum_rdy        = (state_q == ACCUM);
  assign accept          = psum_vld & psum_rdy;
  assign last_pixel      = (pixel_q == pix_m1_q);
  assign last_pass       = (pass_q == pass_m1_q);
  assign addr            = BANK_ADDR_WIDTH'(pixel_q);
  assign ren             = accept && (pass_q != '0);
  assign raddr_accum     = addr;
  assign ready_to_switch = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    pix_m1_d  = pix_m1_q;
    pass_m1_d = pass_m1_q;
    pixel_d   = pixel_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE: begin
        if (config_enable) begin
          pix_m1_d  = cfg_pixels_m1(config_data);
          pass_m1_d = cfg_passes_m1(config_data);
          pixel_d   = '0;
          pass_d    = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (last_pixel) begin
            pixel_d = '0;
            if (last_pass) begin
              state_d = DRAIN;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            pixel_d = pixel_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (config_enable) begin
          pix_m1_d  = cfg_pixels_m1(config_data);
          pass_m1_d = cfg_passes_m1(config_data);
        end
        if (start_new_write_bank) begin
          pixel_d = '0;
          pass_d  = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pix_m1_q  <= '0;
      pass_m1_q <= '0;
      pixel_q   <= '0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      pix_m1_q  <= pix_m1_d;
      pass_m1_q <= pass_m1_d;
      pixel_q   <= pixel_d;
      pass_q    <= pass_d;
    end
  end

  accum_rmw_pipe #(
    .OC0    (OC0),
    .ADDR_W (BANK_ADDR_WIDTH)
  ) u_rmw_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (accept),
    .in_first (pass_q == '0),
    .in_addr  (addr),
    .in_psum  (psum_dat),
    .rdata    (rdata_accum),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata)
  );

endmodule
